// File: rtl/axis_fifo_if.sv
// AXI-Stream link bundle (tvalid/tready/tdata) shared by the FIFO's write and
// read ports; modport s is the subordinate (sink) view, m the manager (source) view.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport s (input tvalid, input tdata, output tready);
    modport m (output tvalid, output tdata, input tready);
endinterface

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with registered tready/tvalid and DEPTH-entry storage.
// Optional flush on `invalidate` is built only when AXIS_FIFO_FLUSH_EN is defined.
module axis_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axis_if.s                            axis_sif,
    axis_if.m                            axis_mif,
    input  logic                         invalidate,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int TDATA_WIDTH = axis_sif.TDATA_WIDTH;
    localparam int PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW          = $clog2(DEPTH+1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "axis_fifo: DEPTH must be a power of two and at least 2");
        end
        if (TDATA_WIDTH == 0 || TDATA_WIDTH != axis_mif.TDATA_WIDTH) begin : g_bad_width
            $fatal(1, "axis_fifo: TDATA_WIDTH must be non-zero and equal on both ports");
        end
    endgenerate

    logic [TDATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic                   tready_q;
    logic                   tvalid_q;
    logic                   sif_ready;
    logic                   mif_valid;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count_next;

    // Handshake: a beat transfers on a clock edge where tvalid and tready are
    // both high; neither side's valid/ready depends combinationally on the
    // other side, and flush gating only ever lowers them.
`ifdef AXIS_FIFO_FLUSH_EN
    assign sif_ready = tready_q & ~invalidate;
    assign mif_valid = tvalid_q & ~invalidate;
`else
    logic unused_invalidate;
    assign unused_invalidate = invalidate;
    assign sif_ready = tready_q;
    assign mif_valid = tvalid_q;
`endif

    assign push = axis_sif.tvalid & sif_ready;
    assign pop  = mif_valid & axis_mif.tready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
`ifdef AXIS_FIFO_FLUSH_EN
        if (invalidate) begin
            count_next = '0;
        end
`endif
    end

    // tready/tvalid are registered from the next occupancy, so no bypass path exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            count    <= count_next;
            tready_q <= (count_next != CW'(DEPTH));
            tvalid_q <= (count_next != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
`ifdef AXIS_FIFO_FLUSH_EN
            if (invalidate) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
            end
`else
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
`endif
        end
    end

    // Storage is left untouched by a flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= axis_sif.tdata;
        end
    end

    assign axis_sif.tready = sif_ready;
    assign axis_mif.tvalid = mif_valid;
    assign axis_mif.tdata  = mem[rptr];
endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo (DEPTH=4, 8-bit data): reset, fill/drain,
// streaming across wrap, random backpressure against a queue model, flush, async reset.
module tb_axis_fifo;
    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int NBEAT = 1000;

    logic       clk;
    logic       rst_n;
    logic       invalidate;
    logic [2:0] count;

    axis_if #(.TDATA_WIDTH(W)) sif ();
    axis_if #(.TDATA_WIDTH(W)) mif ();

    axis_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axis_sif   (sif),
        .axis_mif   (mif),
        .invalidate (invalidate),
        .count      (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [W-1:0] d);
        sif.tvalid = v;
        sif.tdata  = d;
    endtask

    initial begin
        int model_cnt;
        int in_cnt;
        int out_cnt;
        int cycles;
        logic s_v;
        logic m_r;
        logic prev_stall;
        logic [W-1:0] prev_data;
        logic [W-1:0] beats [4];

        rst_n      = 1'b0;
        invalidate = 1'b0;
        mif.tready = 1'b0;
        drive_in(1'b0, '0);
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;

        // reset state
        tick(); tick();
        check("rst_tvalid", 32'(mif.tvalid), 0);
        check("rst_tready", 32'(sif.tready), 0);
        check("rst_count",  32'(count), 0);
        check("rst_tdata",  32'(mif.tdata), 0);
        rst_n = 1'b1;
        #1;
        check("rel_c0_tready", 32'(sif.tready), 0);
        check("rel_c0_tvalid", 32'(mif.tvalid), 0);
        tick();
        check("rel_c1_tready", 32'(sif.tready), 1);
        check("rel_c1_count",  32'(count), 0);

        // fill to full, then drain
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, beats[i]);
            tick();
        end
        drive_in(1'b0, '0);
        check("full_count",  32'(count), 4);
        check("full_tready", 32'(sif.tready), 0);
        check("full_tvalid", 32'(mif.tvalid), 1);
        mif.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_tvalid", 32'(mif.tvalid), 1);
            check("drain_tdata",  32'(mif.tdata), 32'(beats[i]));
            tick();
            check("drain_tready", 32'(sif.tready), 1);
            check("drain_count",  32'(count), 32'(3 - i));
        end
        check("drained_tvalid", 32'(mif.tvalid), 0);

        // streaming 10 beats, one per cycle, across pointer wrap
        for (int k = 0; k < 10; k++) begin
            drive_in(1'b1, W'(k));
            if (k > 0) begin
                check("stream_tvalid", 32'(mif.tvalid), 1);
                check("stream_tdata",  32'(mif.tdata), 32'(k - 1));
                check("stream_count",  32'(count), 1);
            end else begin
                check("stream_first_tvalid", 32'(mif.tvalid), 0);
            end
            tick();
        end
        drive_in(1'b0, '0);
        check("stream_last_tdata", 32'(mif.tdata), 9);
        check("stream_last_count", 32'(count), 1);
        tick();
        check("stream_end_count",  32'(count), 0);
        check("stream_end_tvalid", 32'(mif.tvalid), 0);
        mif.tready = 1'b0;

        // random backpressure against a queue model
        model_cnt  = 0;
        in_cnt     = 0;
        out_cnt    = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (out_cnt < NBEAT && cycles < 20000) begin
            s_v = (in_cnt < NBEAT) && ($urandom_range(0, 3) != 0);
            m_r = ($urandom_range(0, 2) != 0);
            drive_in(s_v, W'(in_cnt));
            mif.tready = m_r;
            check("rnd_count",  32'(count), 32'(model_cnt));
            check("rnd_tready", 32'(sif.tready), 32'(model_cnt != DEPTH));
            check("rnd_tvalid", 32'(mif.tvalid), 32'(model_cnt != 0));
            if (model_cnt != 0) check("rnd_tdata", 32'(mif.tdata), 32'(exp_q[0]));
            if (prev_stall) check("rnd_stable", 32'(mif.tdata), 32'(prev_data));
            prev_stall = (model_cnt != 0) && !m_r;
            prev_data  = (model_cnt != 0) ? exp_q[0] : '0;
            if (m_r && model_cnt != 0) begin
                void'(exp_q.pop_front());
                out_cnt++;
                model_cnt--;
                if (s_v && model_cnt + 1 != DEPTH) begin
                    exp_q.push_back(W'(in_cnt));
                    in_cnt++;
                    model_cnt++;
                end
            end else if (s_v && model_cnt != DEPTH) begin
                exp_q.push_back(W'(in_cnt));
                in_cnt++;
                model_cnt++;
            end
            tick();
            cycles++;
        end
        check("rnd_beats_out", 32'(out_cnt), NBEAT);
        drive_in(1'b0, '0);
        mif.tready = 1'b0;
        check("rnd_end_count", 32'(count), 0);

        // flush with three beats buffered and 0xAA offered
        for (int i = 1; i <= 3; i++) begin
            drive_in(1'b1, W'(i));
            tick();
        end
        drive_in(1'b1, 8'hAA);
        invalidate = 1'b1;
        #1;
`ifdef AXIS_FIFO_FLUSH_EN
        check("flush_tready_gated", 32'(sif.tready), 0);
        check("flush_tvalid_gated", 32'(mif.tvalid), 0);
        tick();
        invalidate = 1'b0;
        drive_in(1'b0, '0);
        check("flush_count",  32'(count), 0);
        check("flush_tvalid", 32'(mif.tvalid), 0);
        check("flush_tready", 32'(sif.tready), 1);
        drive_in(1'b1, 8'hBB);
        tick();
        drive_in(1'b0, '0);
        check("post_flush_tvalid", 32'(mif.tvalid), 1);
        check("post_flush_tdata",  32'(mif.tdata), 32'h0BB);
        mif.tready = 1'b1;
        tick();
        check("post_flush_count", 32'(count), 0);
`else
        check("noflush_tready", 32'(sif.tready), 1);
        check("noflush_tvalid", 32'(mif.tvalid), 1);
        tick();
        invalidate = 1'b0;
        drive_in(1'b0, '0);
        check("noflush_count",  32'(count), 4);
        check("noflush_full",   32'(sif.tready), 0);
        mif.tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("noflush_tdata", 32'(mif.tdata), (i == 4) ? 32'h0AA : 32'(i));
            tick();
        end
        check("noflush_end_count", 32'(count), 0);
`endif
        mif.tready = 1'b0;

        // async reset mid-transfer
        drive_in(1'b1, 8'h5A);
        tick();
        drive_in(1'b1, 8'h5B);
        tick();
        drive_in(1'b0, '0);
        check("pre_areset_count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_tvalid", 32'(mif.tvalid), 0);
        check("areset_tready", 32'(sif.tready), 0);
        check("areset_count",  32'(count), 0);
        check("areset_tdata",  32'(mif.tdata), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rerel_tready", 32'(sif.tready), 1);
        check("rerel_tvalid", 32'(mif.tvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_fifo.md
# axis_fifo

Synchronous AXI-Stream FIFO: a subordinate port accepts beats and a manager port re-emits them in order, with configurable depth and an optional flush. It sits between pipeline stages as deep elastic storage where a 2-entry skid stage is not enough, e.g. between the fetch unit and the decoder. The flush (`invalidate`) discards all buffered beats on a redirect.

## Interface
Parameters:
- DEPTH, default 4: number of entries; power of two, ≥ 2.
- TDATA_WIDTH: taken from the `axis_sif` interface; must equal `axis_mif.TDATA_WIDTH`. Elaboration-time `$fatal` if it is 0 or the widths mismatch, or if DEPTH is invalid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- axis_sif  axis_if.s  TDATA_WIDTH  subordinate (write) side: tvalid/tdata in, tready out.
- axis_mif  axis_if.m  TDATA_WIDTH  manager (read) side: tvalid/tdata out, tready in.
- invalidate  in  1  synchronous flush request.
- count  out  $clog2(DEPTH+1)  current occupancy, registered.

## Operation
- Storage: DEPTH-entry register array.
  - wptr and rptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Occupancy register `count` runs 0..DEPTH.
- Push: when `axis_sif.tvalid && axis_sif.tready`, write `mem[wptr] <= tdata` and increment wptr.
- Pop: when `axis_mif.tvalid && axis_mif.tready`, increment rptr.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `axis_sif.tready` is a register; its next value is `count_next != DEPTH`.
- `axis_mif.tvalid` is a register; its next value is `count_next != 0`.
- `axis_mif.tdata = mem[rptr]`. It is held stable while tvalid is high and tready is low.
- No bypass: a beat written into an empty FIFO is never visible in the same cycle.
- Flush (with the macro, see Configuration):
  - While `invalidate` is high, both tready and tvalid outputs are forced to 0 combinationally, so no handshake occurs that cycle.
  - At that clock edge: wptr, rptr and count are cleared. Memory contents are left as-is.
- Reset: tvalid=0, tready=0, tdata=0 (memory cleared), count=0, pointers=0.

## Timing
- Latency from input handshake to output tvalid: 1 cycle when the FIFO is empty.
- Throughput: 1 beat/cycle on both sides whenever not full / not empty.
- tready rises the first clock edge after rst_n deasserts.
- Full (count=DEPTH):
  - tready=0.
  - A pop in that cycle raises tready in the next cycle. There is no same-cycle refill.
- Empty (count=0):
  - tvalid=0.
  - A push raises tvalid in the next cycle.
- Simultaneous push and pop at count=1: count stays 1, tvalid stays 1, tdata advances to the new beat.
- Pointer wrap from DEPTH-1 to 0 must be seamless; ordering is preserved across the wrap.
- After a flush edge: count=0, tvalid=0, tready=1 in the following cycle.
- Async reset mid-transfer: all outputs drop immediately and every buffered beat is lost.

## Configuration
- Macro: `AXIS_FIFO_FLUSH_EN`.
- Defined: `invalidate` behaves as described in Operation.
- Undefined:
  - `invalidate` is ignored; the port remains so instantiations do not change.
  - The output gating on `invalidate` and the flush logic are not synthesized.

## Test plan
- Reset release, DEPTH=4: cycle 0 after rst_n rises, tready=0 and tvalid=0; cycle 1, tready=1 and count=0.
- Push 0x11, 0x22, 0x33, 0x44 with mif.tready=0 → count=4, tready=0; then mif.tready=1 → output 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, tready=1 from the cycle after the first pop.
- Streaming with both sides valid/ready for 10 beats (0..9) → 1 beat/cycle, first output 1 cycle after first push, count steady at 1, order intact across pointer wrap.
- Random tvalid/tready backpressure over 1000 beats of an incrementing pattern → output sequence matches the input exactly; count never exceeds 4; tdata is stable while stalled.
- With `AXIS_FIFO_FLUSH_EN` defined: load 3 beats, then assert invalidate for 1 cycle while sif.tvalid=1 with 0xAA → no handshake in that cycle, next cycle count=0 and tvalid=0; 0xAA is not stored unless presented again.
- Without `AXIS_FIFO_FLUSH_EN`: same stimulus → invalidate is ignored, the 3 beats are delivered, and 0xAA is accepted.
